uart_tx_buf: RTL and testbench

Buffered UART transmitter that sits directly downstream of the UART control stage and converts its byte-plus-strobe output into a serial 8-N-1 (optionally 8-E-1 / 8-O-1) line. Bytes are captured on the rising edge of `wrsig` into a small FIFO and serialised LSB first at `OVERSAMPLE` clocks per bit. The FIFO absorbs overlapping requests from the echo and banner paths without corrupting frames in flight. `clk` is the same oversampled baud clock used by the control stage, 16× baud by default.

---
 rtl/uart_tx_buf.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered UART transmitter. A byte is captured on every rising edge of
//   wrsig into a small FIFO, then serialised LSB first as 8-N-1. With
//   PARITY_EN set the frame is 8-E-1, or 8-O-1 when PARITY_ODD is also set.
//   Each serial bit lasts OVERSAMPLE clk cycles. Frames queued in the FIFO are
//   sent back to back, with no idle gap between them.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   OVERSAMPLE  clk cycles per serial bit (>= 2)
//   PARITY_EN   1 inserts a parity bit after D7
//   PARITY_ODD  parity sense when enabled: 0 = even, 1 = odd
//
// Ports
//   clk       in   oversampled baud clock, rising edge
//   rst_n     in   synchronous active-low reset
//   wrsig     in   write strobe; each 0->1 transition writes one byte
//   datain    in   byte to enqueue, sampled on the edge that detects the rise
//   tx        out  serial line, registered, idles high
//   idle      out  FSM in IDLE and FIFO empty
//   full      out  FIFO holds DEPTH entries
//   overflow  out  one-cycle pulse when a write is dropped
// -----------------------------------------------------------------------------
module uart_tx_buf #(
    parameter int DEPTH      = 4,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wrsig,
    input  logic [7:0] datain,
    output logic       tx,
    output logic       idle,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Edge detect and FIFO state
    logic          wr_prev_q;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          overflow_q;

    // Serialiser state
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          tx_q;

    logic          wr_req;
    logic          empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          bit_done;
    logic [AW:0]   occupancy;
    logic [7:0]    head;

    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch can be inferred.
        wr_req    = wrsig & ~wr_prev_q;
        occupancy = wptr_q - rptr_q;
        empty     = (wptr_q == rptr_q);
        fifo_full = (occupancy == FULL_COUNT);
        bit_done  = (timer_q == TIMER_LAST);
        head      = mem_q[rptr_q[AW-1:0]];
        // A full FIFO drops the write even if a pop happens on the same edge.
        push      = wr_req & ~fifo_full;
        pop       = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_done));
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (push) wptr_d = wptr_q + (AW + 1)'(1);
        if (pop)  rptr_d = rptr_q + (AW + 1)'(1);
    end

    // wr_prev resets to 1, so a wrsig already high at reset release is not a write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (!rst_n) begin
            wr_prev_q  <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_prev_q  <= wrsig;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= wr_req & fifo_full;
        end
    end

    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= datain;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            timer_q <= bit_done ? '0 : timer_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (pop) begin
                        shift_q  <= head;
                        parity_q <= (^head) ^ PARITY_ODD;
                        tx_q     <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            // The shift register moves right so that the next bit is always at index 1.
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            // When the FIFO is not empty, the next start bit follows with no idle gap.
                            shift_q  <= head;
                            parity_q <= (^head) ^ PARITY_ODD;
                            tx_q     <= 1'b0;
                            state_q  <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign idle     = (state_q == S_IDLE) & empty;
    assign full     = fifo_full;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//   Directed bench for uart_tx_buf. One instance uses the default parameters.
//   A second instance uses 8-O-1. Expected frames are hand-computed 11-bit
//   patterns in transmit order: bit 0 is the start bit. Each bit is checked
//   to hold its value for all OVERSAMPLE cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

    localparam int OS = 16;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wrsig, wrsig_p;
    logic [7:0] datain, datain_p;
    logic       tx, idle, full, overflow;
    logic       tx_p, idle_p, full_p, overflow_p;

    int n_checks = 0;
    int n_pass   = 0;
    int ovf_cnt  = 0;

    always #5 clk = ~clk;

    uart_tx_buf #(.DEPTH(4), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wrsig(wrsig), .datain(datain),
        .tx(tx), .idle(idle), .full(full), .overflow(overflow)
    );

    uart_tx_buf #(.DEPTH(4), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .wrsig(wrsig_p), .datain(datain_p),
        .tx(tx_p), .idle(idle_p), .full(full_p), .overflow(overflow_p)
    );

    always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic get_tx(input bit par);
        return par ? tx_p : tx;
    endfunction

    function automatic logic get_idle(input bit par);
        return par ? idle_p : idle;
    endfunction

    // Drive a one-cycle strobe. Return full as it was before the capture edge and overflow just after it.
    task automatic strobe(input bit par, input logic [7:0] d, output logic f_before, output logic o_after);
        @(negedge clk);
        f_before = par ? full_p : full;
        if (par) begin wrsig_p = 1'b1; datain_p = d; end
        else     begin wrsig   = 1'b1; datain   = d; end
        @(negedge clk);
        o_after = par ? overflow_p : overflow;
        if (par) wrsig_p = 1'b0;
        else     wrsig   = 1'b0;
    endtask

    // Wait (bounded) for the start bit, then check every cycle of an nbits-bit frame.
    task automatic run_frame(input bit par, input int nbits, input logic [10:0] exp_bits,
                             input logic exp_idle_end, input string name, output int waited);
        logic [10:0] obs;
        int glitches;
        int idle_hi;
        logic t;
        obs = '0;
        glitches = 0;
        idle_hi = 0;
        waited = 0;
        while (get_tx(par) !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({name, " start seen"}, 32'(get_tx(par)), 32'd0);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < OS; c++) begin
                t = get_tx(par);
                if (c == 0) obs[b] = t;
                else if (t !== obs[b]) glitches++;
                if (get_idle(par) !== 1'b0) idle_hi++;
                @(negedge clk);
            end
        end
        check({name, " bits"}, 32'(obs), 32'(exp_bits));
        check({name, " bit timing"}, glitches, 0);
        check({name, " idle low in frame"}, idle_hi, 0);
        check({name, " idle after frame"}, 32'(get_idle(par)), 32'(exp_idle_end));
    endtask

    task automatic quiet(input int n, input string name);
        int lows;
        int busy;
        lows = 0;
        busy = 0;
        repeat (n) begin
            if (tx !== 1'b1) lows++;
            if (idle !== 1'b1) busy++;
            @(negedge clk);
        end
        check({name, " tx stays high"}, lows, 0);
        check({name, " idle stays high"}, busy, 0);
    endtask

    initial begin
        vec_t        vecs [6];
        logic [7:0]  hello [5];
        logic [10:0] hello_f [5];
        logic [7:0]  ob [6];
        logic [10:0] ob_f [6];
        logic        fb, oa;
        int          w;
        int          ovf0;

        vecs[0] = '{data: 8'h48, frame: 11'h290};
        vecs[1] = '{data: 8'h00, frame: 11'h200};
        vecs[2] = '{data: 8'hFF, frame: 11'h3FE};
        vecs[3] = '{data: 8'hA5, frame: 11'h34A};
        vecs[4] = '{data: 8'h01, frame: 11'h202};
        vecs[5] = '{data: 8'h80, frame: 11'h300};

        hello[0] = 8'h48; hello_f[0] = 11'h290;
        hello[1] = 8'h65; hello_f[1] = 11'h2CA;
        hello[2] = 8'h6C; hello_f[2] = 11'h2D8;
        hello[3] = 8'h6C; hello_f[3] = 11'h2D8;
        hello[4] = 8'h6F; hello_f[4] = 11'h2DE;

        ob[0] = 8'h11; ob_f[0] = 11'h222;
        ob[1] = 8'h22; ob_f[1] = 11'h244;
        ob[2] = 8'h33; ob_f[2] = 11'h266;
        ob[3] = 8'h44; ob_f[3] = 11'h288;
        ob[4] = 8'h55; ob_f[4] = 11'h2AA;
        ob[5] = 8'h66; ob_f[5] = 11'h2CC;

        rst_n = 1'b0; wrsig = 1'b0; wrsig_p = 1'b0; datain = '0; datain_p = '0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset idle", 32'(idle), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset tx parity dut", 32'(tx_p), 32'd1);
        rst_n = 1'b1;

        // Single bytes from the table: latency 1, full frame shape, idle after 160 cycles.
        for (int i = 0; i < 6; i++) begin
            strobe(1'b0, vecs[i].data, fb, oa);
            run_frame(1'b0, 10, vecs[i].frame, 1'b1, $sformatf("vec%0d", i), w);
            check($sformatf("vec%0d latency", i), w, 1);
        end

        // Burst "Hello" with strobes every 2 cycles.
        ovf0 = ovf_cnt;
        fork
            begin
                logic f1, o1;
                for (int i = 0; i < 5; i++) strobe(1'b0, hello[i], f1, o1);
                check("burst full after 5th write", 32'(full), 32'd1);
            end
            begin
                int wb;
                for (int i = 0; i < 5; i++) begin
                    run_frame(1'b0, 10, hello_f[i], (i == 4), $sformatf("hello%0d", i), wb);
                    if (i > 0) check($sformatf("hello%0d contiguous", i), wb, 0);
                end
            end
        join
        check("burst no overflow", ovf_cnt - ovf0, 0);

        // Six strobes into a 4-deep FIFO: the 6th write is dropped.
        ovf0 = ovf_cnt;
        fork
            begin
                logic f2, o2;
                for (int i = 0; i < 6; i++) begin
                    strobe(1'b0, ob[i], f2, o2);
                    if (i == 4) check("ovf full before 5th", 32'(f2), 32'd0);
                    if (i == 5) begin
                        check("ovf full during 6th", 32'(f2), 32'd1);
                        check("ovf pulse on 6th", 32'(o2), 32'd1);
                    end
                end
            end
            begin
                int wo;
                for (int i = 0; i < 5; i++)
                    run_frame(1'b0, 10, ob_f[i], (i == 4), $sformatf("ovf%0d", i), wo);
            end
        join
        quiet(200, "ovf no 6th frame");
        check("ovf single pulse", ovf_cnt - ovf0, 1);

        // Level-held strobe sends exactly one frame.
        fork
            begin
                @(negedge clk);
                wrsig = 1'b1; datain = 8'h55;
                repeat (50) @(negedge clk);
                wrsig = 1'b0;
            end
            begin
                int wh;
                run_frame(1'b0, 10, 11'h2AA, 1'b1, "held", wh);
            end
        join
        quiet(100, "held one frame");
        strobe(1'b0, 8'h55, fb, oa);
        run_frame(1'b0, 10, 11'h2AA, 1'b1, "held rearm", w);
        check("held rearm latency", w, 1);

        // A wrsig that is high across reset release is not a write.
        @(negedge clk);
        wrsig = 1'b1; datain = 8'hC3; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet(20, "wrsig held over reset");
        wrsig = 1'b0;
        quiet(200, "after held reset release");

        // Odd parity: 0x07 -> parity 0, 0x03 -> parity 1; 176-cycle contiguous frames.
        fork
            begin
                logic f3, o3;
                strobe(1'b1, 8'h07, f3, o3);
                strobe(1'b1, 8'h03, f3, o3);
            end
            begin
                int wp;
                run_frame(1'b1, 11, 11'h40E, 1'b0, "par07", wp);
                run_frame(1'b1, 11, 11'h606, 1'b1, "par03", wp);
                check("par03 contiguous", wp, 0);
            end
        join

        // Reset during D3 of the first of three queued frames.
        strobe(1'b0, 8'h1A, fb, oa);
        strobe(1'b0, 8'h34, fb, oa);
        strobe(1'b0, 8'h56, fb, oa);
        check("mid start bit", 32'(tx), 32'd0);
        repeat (67) @(negedge clk);
        check("mid D3 of 0x1A", 32'(tx), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset tx", 32'(tx), 32'd1);
        check("mid reset idle", 32'(idle), 32'd1);
        check("mid reset full", 32'(full), 32'd0);
        rst_n = 1'b1;
        quiet(400, "after mid reset");
        strobe(1'b0, 8'h81, fb, oa);
        run_frame(1'b0, 10, 11'h302, 1'b1, "post reset", w);
        check("post reset latency", w, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
